// File: rtl/text_num_parser.sv
// Serial ASCII decimal parser: accumulates digit runs into unsigned values and
// emits each completed number (or an error) on a valid/ready output handshake.

module text2nibble (
   input  logic [7:0] char_i,
   output logic [3:0] nib_o
);
   // Only '0'..'9' map to a value; everything else reads as 4'hF.
   always_comb begin
      nib_o = 4'hF;
      if (char_i >= 8'h30 && char_i <= 8'h39) nib_o = char_i[3:0];
   end
endmodule

module text_num_parser #(
   parameter int WIDTH = 16,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_char,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             out_err,
   output logic [CNTW-1:0]  num_cnt
);
   typedef enum logic [1:0] {IDLE, ACCUM, SKIP, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] acc_q;
   logic             err_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_value_q;
   logic             out_err_q;
   logic [CNTW-1:0]  num_cnt_q;

   logic [3:0]       nib;
   logic             is_digit, is_term, accept, ovf;
   logic [WIDTH+3:0] mac_d;

   text2nibble u_t2n (.char_i(in_char), .nib_o(nib));

   assign is_digit = (nib != 4'hF);
   assign is_term  = (in_char == 8'h20) || (in_char == 8'h0D) ||
                     (in_char == 8'h0A) || (in_char == 8'h2C);
   assign in_ready = (state_q != DONE);
   assign accept   = in_valid && in_ready;

   // Four guard bits hold acc*10+9 for any WIDTH-bit acc.
   assign mac_d = ({4'b0, acc_q} * (WIDTH+4)'(10)) + (WIDTH+4)'(nib);
   assign ovf   = |mac_d[WIDTH+3:WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_err_q   <= 1'b0;
         num_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept && !is_term) begin
               if (is_digit) begin
                  acc_q   <= WIDTH'(nib);
                  state_q <= ACCUM;
               end else begin
                  err_q   <= 1'b1;
                  state_q <= SKIP;
               end
            end
            ACCUM: if (accept) begin
               if (is_digit && !ovf) begin
                  acc_q <= mac_d[WIDTH-1:0];
               end else if (is_term) begin
                  out_valid_q <= 1'b1;
                  out_value_q <= acc_q;
                  out_err_q   <= 1'b0;
                  state_q     <= DONE;
               end else begin
                  err_q   <= 1'b1;
                  state_q <= SKIP;
               end
            end
            SKIP: if (accept && is_term) begin
               out_valid_q <= 1'b1;
               out_value_q <= '0;
               out_err_q   <= 1'b1;
               state_q     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               out_value_q <= '0;
               out_err_q   <= 1'b0;
               acc_q       <= '0;
               err_q       <= 1'b0;
               num_cnt_q   <= num_cnt_q + 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign out_err   = out_err_q;
   assign num_cnt   = num_cnt_q;
endmodule
